// File: rtl/chunked_add_sub.sv
// chunked_add_sub: multi-cycle adder/subtractor that works through a WIDTH-bit
// operation CHUNK bits per clock, starting at the LSB slice and carrying
// between slices through a one-bit register.
//
// Ports
//   clk    sole clock, rising edge
//   rst    synchronous, active-high reset
//   start  request, sampled only while busy=0
//   sub    0: a+b+cin, 1: a-b (a+~b+1, cin ignored)
//   a, b   operands, index 0 = MSB
//   cin    carry-in for add mode
//   busy   high while slices are being computed
//   done   one-cycle pulse; sum/cout/ovf valid from this cycle on
//   sum    result, index 0 = MSB
//   cout   carry out of the MSB (sub mode: 1 = no borrow)
//   ovf    two's-complement overflow
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one slice per clock, LSB slice first
// S_DONE | result just landed; done pulse, may accept a new start
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  // Operands are kept with a conventional descending range internally so
  // that bit 0 is the LSB and slice k sits at [k*CHUNK +: CHUNK].
  logic [WIDTH-1:0] a_q, b_q, shadow, shadow_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] a_sl, b_sl, res_sl;
  logic             c_sl;
  logic             last;
  logic             accept;
  logic             ovf_nxt;

  always_comb begin
    a_sh          = a_q >> (cnt * CHUNK);
    b_sh          = b_q >> (cnt * CHUNK);
    a_sl          = a_sh[CHUNK-1:0];
    b_sl          = b_sh[CHUNK-1:0];
    {c_sl, res_sl} = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(carry_q);
    // shadow is cleared on accept, so OR-ing the slice in is enough
    shadow_nxt    = shadow | (WIDTH'(res_sl) << (cnt * CHUNK));
    last          = (cnt == CW'(NCH - 1));
    // carry into the MSB is recovered from the MSB sum bit and its inputs
    ovf_nxt       = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ shadow_nxt[WIDTH-1] ^ c_sl;
  end

  assign accept = start && (state != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      shadow  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      shadow  <= '0;
      cnt     <= '0;
    end else if (state == S_RUN) begin
      shadow  <= shadow_nxt;
      carry_q <= c_sl;
      if (last) begin
        sum  <= shadow_nxt;
        cout <= c_sl;
        ovf  <= ovf_nxt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: directed vectors on the 16/4 configuration,
// then random add/sub ops shared by 16/1, 16/4, 16/16 and 8/2 instances
// compared against an independent full-width model.
module tb_chunked_add_sub;

  logic        clk = 1'b0;
  logic        rst, start, sub, cin;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;

  logic        busy_c1, done_c1, cout_c1, ovf_c1;
  logic        busy_m, done_m, cout_m, ovf_m;
  logic        busy_c16, done_c16, cout_c16, ovf_c16;
  logic        busy_w8, done_w8, cout_w8, ovf_w8;
  logic [0:15] sum_c1, sum_m, sum_c16;
  logic [0:7]  sum_w8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  chunked_add_sub #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a16), .b(b16), .cin(cin),
    .busy(busy_c1), .done(done_c1), .sum(sum_c1), .cout(cout_c1), .ovf(ovf_c1));
  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) u_main (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a16), .b(b16), .cin(cin),
    .busy(busy_m), .done(done_m), .sum(sum_m), .cout(cout_m), .ovf(ovf_m));
  chunked_add_sub #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a16), .b(b16), .cin(cin),
    .busy(busy_c16), .done(done_c16), .sum(sum_c16), .cout(cout_c16), .ovf(ovf_c16));
  chunked_add_sub #(.WIDTH(8), .CHUNK(2)) u_w8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a8), .b(b8), .cin(cin),
    .busy(busy_w8), .done(done_w8), .sum(sum_w8), .cout(cout_w8), .ovf(ovf_w8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // returns {cout, ovf, sum[15:0]}; w is 16 or 8
  function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                        input logic sv, input logic cv);
    logic [15:0] x, y, s;
    logic [16:0] full;
    logic        co, ov;
    x    = av;
    y    = sv ? ~bv : bv;
    if (w == 8) begin
      x = x & 16'h00FF;
      y = y & 16'h00FF;
    end
    full = {1'b0, x} + {1'b0, y} + {16'b0, (sv ? 1'b1 : cv)};
    if (w == 8) begin
      s  = {8'h00, full[7:0]};
      co = full[8];
      ov = (x[7] == y[7]) && (s[7] != x[7]);
    end else begin
      s  = full[15:0];
      co = full[16];
      ov = (x[15] == y[15]) && (s[15] != x[15]);
    end
    return {co, ov, s};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic cv,
                        input logic [15:0] es, input logic ec, input logic eo);
    a16 = av; b16 = bv; sub = sv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check({tag, " busy/done c", $sformatf("%0d", i)}, {30'b0, busy_m, done_m}, 32'h2);
      tick();
    end
    check({tag, " busy/done c5"}, {30'b0, busy_m, done_m}, 32'h1);
    check({tag, " sum"}, {16'b0, sum_m}, {16'b0, es});
    check({tag, " cout"}, {31'b0, cout_m}, {31'b0, ec});
    check({tag, " ovf"}, {31'b0, ovf_m}, {31'b0, eo});
    tick();
    check({tag, " done c6"}, {31'b0, done_m}, 32'h0);
  endtask

  initial begin
    logic [15:0] av, bv;
    logic        sv, cv;
    logic [17:0] e16, e8;
    int          lat [4];
    int          exp_lat [4];
    logic [15:0] gs [4];
    logic [3:0]  gc, go, dn;
    int          cyc, pulses;

    exp_lat = '{17, 5, 2, 5};
    rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b0;
    a16 = 16'h1234; b16 = 16'h4321; a8 = 8'h00; b8 = 8'h00;

    // reset held two cycles with start high
    tick();
    tick();
    check("rst busy", {31'b0, busy_m}, 32'h0);
    check("rst done", {31'b0, done_m}, 32'h0);
    check("rst sum", {16'b0, sum_m}, 32'h0);
    check("rst cout", {31'b0, cout_m}, 32'h0);
    check("rst ovf", {31'b0, ovf_m}, 32'h0);
    rst = 1'b0; start = 1'b0;
    tick();
    tick();
    check("post-rst idle", {30'b0, busy_m, done_m}, 32'h0);

    run_op("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add cin",  16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
    run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub neg",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub cin",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub cin2", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start during RUN is ignored, start in the done cycle is accepted
    a16 = 16'h1234; b16 = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick();                                   // cycle 2
    a16 = 16'hFFFF; b16 = 16'hFFFF; start = 1'b1;
    tick();                                   // cycle 3
    start = 1'b0;
    tick();                                   // cycle 4
    tick();                                   // cycle 5
    check("ign done", {30'b0, busy_m, done_m}, 32'h1);
    check("ign sum", {16'b0, sum_m}, 32'h5555);
    a16 = 16'h0005; b16 = 16'h0007; sub = 1'b1; start = 1'b1;
    tick();                                   // cycle 6
    start = 1'b0;
    check("b2b busy", {31'b0, busy_m}, 32'h1);
    for (int i = 7; i <= 9; i++) tick();      // cycle 9
    check("b2b no early done", {31'b0, done_m}, 32'h0);
    check("b2b sum hold", {16'b0, sum_m}, 32'h5555);
    tick();                                   // cycle 10
    check("b2b done c10", {30'b0, busy_m, done_m}, 32'h1);
    check("b2b sum", {16'b0, sum_m}, 32'hFFFE);
    check("b2b cout", {31'b0, cout_m}, 32'h0);

    // reset mid-RUN
    a16 = 16'h1234; b16 = 16'h4321; sub = 1'b0; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", {31'b0, busy_m}, 32'h0);
    check("midrst sum", {16'b0, sum_m}, 32'h0);
    check("midrst cout/ovf", {30'b0, cout_m, ovf_m}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_m) pulses++;
      tick();
    end
    check("midrst no done", pulses, 0);

    // random ops on all configurations
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int n = 0; n < 1000; n++) begin
      av = 16'($urandom); bv = 16'($urandom);
      sv = 1'($urandom); cv = 1'($urandom);
      a16 = av; b16 = bv; a8 = av[7:0]; b8 = bv[7:0]; sub = sv; cin = cv;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      lat = '{0, 0, 0, 0};
      while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0 || lat[3] == 0) && cyc < 40) begin
        dn = {done_w8, done_c16, done_m, done_c1};
        for (int i = 0; i < 4; i++) if (dn[i] && lat[i] == 0) lat[i] = cyc;
        tick();
        cyc++;
      end
      e16 = model(16, av, bv, sv, cv);
      e8  = model(8, {8'h00, av[7:0]}, {8'h00, bv[7:0]}, sv, cv);
      gs[0] = sum_c1; gs[1] = sum_m; gs[2] = sum_c16; gs[3] = {8'h00, sum_w8};
      gc = {cout_w8, cout_c16, cout_m, cout_c1};
      go = {ovf_w8, ovf_c16, ovf_m, ovf_c1};
      for (int i = 0; i < 4; i++) begin
        logic [17:0] e;
        e = (i == 3) ? e8 : e16;
        check($sformatf("rnd%0d cfg%0d latency", n, i), lat[i], exp_lat[i]);
        check($sformatf("rnd%0d cfg%0d sum", n, i), {16'b0, gs[i]}, {16'b0, e[15:0]});
        check($sformatf("rnd%0d cfg%0d cout", n, i), {31'b0, gc[i]}, {31'b0, e[17]});
        check($sformatf("rnd%0d cfg%0d ovf", n, i), {31'b0, go[i]}, {31'b0, e[16]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
